// File: rtl/ads1220_seq_ctrl.sv
// ADS1220 command sequencer: power-up RESET, WREG of four config registers, START/SYNC,
// then DRDY_n-triggered 24-bit reads through an 8-bit go/ok SPI byte engine.
module ads1220_seq_ctrl #(
  parameter int unsigned RST_WAIT_CYC = 3000,
  parameter int unsigned GAP_CYC      = 4,
  parameter int unsigned DRDY_TO_CYC  = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] cfg,
  input  logic        cfg_req,
  input  logic        drdy_n,
  output logic        cs_n,
  output logic        spi_go,
  output logic [7:0]  spi_wrdat,
  input  logic [7:0]  spi_rddat,
  input  logic        spi_ok,
  output logic [23:0] sample,
  output logic        sample_vld,
  output logic        busy,
  output logic        err_to
);

  localparam int unsigned RstW = $clog2(RST_WAIT_CYC + 1);
  localparam int unsigned ToW  = $clog2(DRDY_TO_CYC + 1);
  localparam int unsigned GapW = $clog2(GAP_CYC + 1);

  localparam logic [7:0] CmdReset = 8'h06;
  localparam logic [7:0] CmdWreg  = 8'h43;
  localparam logic [7:0] CmdStart = 8'h08;
  localparam logic [7:0] CmdNop   = 8'h00;

  typedef enum logic [2:0] {
    StIdle, StRstCmd, StRstWait, StCfg, StStart, StWaitDrdy, StRead
  } state_e;

  typedef enum logic [1:0] {SubIdle, SubGo, SubGap} sub_e;

  state_e           state_q, state_d;
  sub_e             sub_q, sub_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [2:0]       idx_q, idx_d;
  logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [31:0]      cfg_q, cfg_d;
  logic             cfg_pend_q, cfg_pend_d;
  logic [23:0]      rd_sh_q, rd_sh_d;
  logic             drdy_meta_q, drdy_sync_q, drdy_prev_q;
  logic             cs_n_q, cs_n_d;
  logic             go_q, go_d;
  logic [7:0]       wrdat_q, wrdat_d;
  logic [23:0]      sample_q, sample_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic             drdy_fall;
  logic             send_state;
  logic             byte_done;
  logic             cfg_entry;
  logic [7:0]       cur_byte;

  assign drdy_fall  = drdy_prev_q & ~drdy_sync_q;
  assign send_state = state_q inside {StRstCmd, StCfg, StStart, StRead};

  always_comb begin
    cur_byte = CmdNop;
    unique case (state_q)
      StRstCmd: cur_byte = CmdReset;
      StStart:  cur_byte = CmdStart;
      StCfg: begin
        unique case (idx_q)
          3'd0:    cur_byte = CmdWreg;
          3'd1:    cur_byte = cfg_q[7:0];
          3'd2:    cur_byte = cfg_q[15:8];
          3'd3:    cur_byte = cfg_q[23:16];
          3'd4:    cur_byte = cfg_q[31:24];
          default: cur_byte = CmdNop;
        endcase
      end
      default:  cur_byte = CmdNop;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    rst_cnt_d = '0;
    to_cnt_d  = '0;
    cfg_d     = cfg_q;
    rd_sh_d   = rd_sh_q;
    go_d      = go_q;
    wrdat_d   = wrdat_q;
    sample_d  = sample_q;
    vld_d     = 1'b0;
    err_d     = err_q;
    byte_done = 1'b0;

    // Byte handshake: go held until ok, then GAP_CYC low cycles before the next launch.
    unique case (sub_q)
      SubIdle: begin
        if (send_state && en) begin
          go_d    = 1'b1;
          wrdat_d = cur_byte;
          sub_d   = SubGo;
        end
      end
      SubGo: begin
        if (spi_ok) begin
          go_d  = 1'b0;
          gap_d = '0;
          sub_d = SubGap;
          if (state_q == StRead) rd_sh_d = {rd_sh_q[15:0], spi_rddat};
        end
      end
      SubGap: begin
        if (gap_q == GapW'(GAP_CYC - 2)) begin
          byte_done = 1'b1;
          sub_d     = SubIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: sub_d = SubIdle;
    endcase

    unique case (state_q)
      StIdle: begin
        if (en) state_d = StRstCmd;
      end
      StRstCmd: begin
        if (byte_done) state_d = StRstWait;
      end
      StRstWait: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RstW'(RST_WAIT_CYC - 1)) state_d = StCfg;
      end
      StCfg: begin
        if (byte_done) begin
          if (idx_q == 3'd4) state_d = StStart;
          else idx_d = idx_q + 3'd1;
        end
      end
      StStart: begin
        if (byte_done) state_d = StWaitDrdy;
      end
      StWaitDrdy: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (drdy_fall) begin
          state_d = StRead;
        end else if (cfg_pend_q) begin
          state_d = StCfg;
        end else if (to_cnt_q == ToW'(DRDY_TO_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = StStart;
        end
      end
      StRead: begin
        if (byte_done) begin
          if (idx_q == 3'd2) begin
            // A read cut short by en low never reaches here with en high.
            if (en) begin
              sample_d = rd_sh_q;
              vld_d    = 1'b1;
            end
            state_d = cfg_q[10] ? StWaitDrdy : StStart;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // en low: let an in-flight byte finish its gap, never launch another.
    if (!en) begin
      err_d = 1'b0;
      if (state_q inside {StRstWait, StWaitDrdy}) state_d = StIdle;
      else if (send_state && (sub_q == SubIdle || byte_done)) state_d = StIdle;
    end

    if (state_d != state_q) idx_d = '0;
    if (cfg_entry) cfg_d = cfg;
  end

  assign cfg_entry  = (state_d == StCfg) && (state_q != StCfg);
  assign cfg_pend_d = (cfg_pend_q && !cfg_entry) || cfg_req;
  assign cs_n_d     = (state_d == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sub_q       <= SubIdle;
      gap_q       <= '0;
      idx_q       <= '0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      cfg_q       <= '0;
      cfg_pend_q  <= 1'b0;
      rd_sh_q     <= '0;
      drdy_meta_q <= 1'b1;
      drdy_sync_q <= 1'b1;
      drdy_prev_q <= 1'b1;
      cs_n_q      <= 1'b1;
      go_q        <= 1'b0;
      wrdat_q     <= '0;
      sample_q    <= '0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      cfg_q       <= cfg_d;
      cfg_pend_q  <= cfg_pend_d;
      rd_sh_q     <= rd_sh_d;
      drdy_meta_q <= drdy_n;
      drdy_sync_q <= drdy_meta_q;
      drdy_prev_q <= drdy_sync_q;
      cs_n_q      <= cs_n_d;
      go_q        <= go_d;
      wrdat_q     <= wrdat_d;
      sample_q    <= sample_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign spi_go     = go_q;
  assign spi_wrdat  = wrdat_q;
  assign sample     = sample_q;
  assign sample_vld = vld_q;
  assign busy       = (state_q != StIdle);
  assign err_to     = err_q;

endmodule

// File: tb/tb_ads1220_seq_ctrl.sv
// Directed bench for ads1220_seq_ctrl with a behavioural SPI byte engine and MISO queue.
module tb_ads1220_seq_ctrl;

  localparam int unsigned RstWait = 20;
  localparam int unsigned Gap     = 2;
  localparam int unsigned DrdyTo  = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] cfg;
  logic        cfg_req;
  logic        drdy_n;
  logic        cs_n;
  logic        spi_go;
  logic [7:0]  spi_wrdat;
  logic [7:0]  spi_rddat;
  logic        spi_ok;
  logic [23:0] sample;
  logic        sample_vld;
  logic        busy;
  logic        err_to;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int stab_err = 0;
  int eng_cnt = 0;
  int vld_base;
  int wcnt;
  logic        prev_go = 1'b0;
  logic [7:0]  prev_wd = 8'h00;
  logic [7:0]  tx_log[$];
  int          tx_cyc[$];
  logic [7:0]  miso[$];
  logic [7:0]  exp_pwr[7];

  ads1220_seq_ctrl #(
    .RST_WAIT_CYC(RstWait),
    .GAP_CYC     (Gap),
    .DRDY_TO_CYC (DrdyTo)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg       (cfg),
    .cfg_req   (cfg_req),
    .drdy_n    (drdy_n),
    .cs_n      (cs_n),
    .spi_go    (spi_go),
    .spi_wrdat (spi_wrdat),
    .spi_rddat (spi_rddat),
    .spi_ok    (spi_ok),
    .sample    (sample),
    .sample_vld(sample_vld),
    .busy      (busy),
    .err_to    (err_to)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte engine: ok four clocks after go, held while go stays high.
  always @(posedge clk) begin
    if (!spi_go) begin
      spi_ok  <= 1'b0;
      eng_cnt <= 0;
    end else if (!spi_ok) begin
      if (eng_cnt == 3) begin
        spi_ok    <= 1'b1;
        spi_rddat <= (miso.size() > 0) ? miso.pop_front() : 8'h00;
        tx_log.push_back(spi_wrdat);
        tx_cyc.push_back(cyc);
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (sample_vld) vld_cnt++;
    if (spi_go && prev_go && spi_wrdat != prev_wd) stab_err++;
    prev_go = spi_go;
    prev_wd = spi_wrdat;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int i = 0;
    while (tx_log.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(tx_log.size() >= n), 32'd1);
  endtask

  task automatic wait_vld(input int base, input int budget, input string tag);
    int i = 0;
    while (vld_cnt <= base && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(vld_cnt > base), 32'd1);
  endtask

  task automatic pulse_drdy();
    @(negedge clk);
    drdy_n = 1'b0;
    repeat (3) @(negedge clk);
    drdy_n = 1'b1;
  endtask

  initial begin
    spi_ok    = 1'b0;
    spi_rddat = 8'h00;
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg       = 32'h0;
    cfg_req   = 1'b0;
    drdy_n    = 1'b1;
    exp_pwr   = '{8'h06, 8'h43, 8'h00, 8'h04, 8'h00, 8'h00, 8'h08};
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_go", 32'(spi_go), 32'd0);
    check("rst_wrdat", 32'(spi_wrdat), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_vld", 32'(sample_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_to), 32'd0);
    rst_n = 1'b1;

    // Power-up sequence, continuous mode (reg1 bit2 set).
    cfg = 32'h00_00_04_00;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pwr_cs_n_low", 32'(cs_n), 32'd0);
    check("pwr_busy", 32'(busy), 32'd1);
    wait_log(7, 400, "pwr_seq_done");
    for (int i = 0; i < 7; i++) check($sformatf("pwr_byte%0d", i), 32'(tx_log[i]), 32'(exp_pwr[i]));
    check("pwr_rst_wait", 32'((tx_cyc[1] - tx_cyc[0]) >= 20 && (tx_cyc[1] - tx_cyc[0]) < 40), 32'd1);

    // Continuous read: no START afterwards.
    tx_log.delete();
    miso = '{8'h12, 8'h34, 8'h56};
    vld_base = vld_cnt;
    pulse_drdy();
    wait_vld(vld_base, 200, "cont_vld_seen");
    repeat (40) @(negedge clk);
    check("cont_sample", 32'(sample), 32'h123456);
    check("cont_vld_once", 32'(vld_cnt - vld_base), 32'd1);
    check("cont_nbytes", 32'(tx_log.size()), 32'd3);
    check("cont_byte0", 32'(tx_log[0]), 32'h00);
    check("cont_byte2", 32'(tx_log[2]), 32'h00);

    // cfg_req during a read: read completes, then WREG with new cfg, then START.
    tx_log.delete();
    miso = '{8'hAA, 8'hBB, 8'hCC};
    cfg = 32'h00_00_00_00;
    vld_base = vld_cnt;
    pulse_drdy();
    wait_log(1, 100, "req_first_byte");
    @(negedge clk);
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    wait_log(9, 300, "req_seq_done");
    check("req_vld_once", 32'(vld_cnt - vld_base), 32'd1);
    check("req_sample", 32'(sample), 32'hAABBCC);
    check("req_byte2_nop", 32'(tx_log[2]), 32'h00);
    check("req_byte3_wreg", 32'(tx_log[3]), 32'h43);
    check("req_byte5_reg1", 32'(tx_log[5]), 32'h00);
    check("req_byte8_start", 32'(tx_log[8]), 32'h08);

    // Single-shot read of a negative value, followed by START.
    tx_log.delete();
    miso = '{8'hFF, 8'hFF, 8'hFE};
    vld_base = vld_cnt;
    pulse_drdy();
    wait_log(4, 200, "ss_seq_done");
    check("ss_sample_neg2", 32'(sample), 32'h00FFFFFE);
    check("ss_vld_once", 32'(vld_cnt - vld_base), 32'd1);
    check("ss_start_resent", 32'(tx_log[3]), 32'h08);

    // DRDY timeout with drdy_n held high.
    repeat (80) @(negedge clk);
    check("to_not_early", 32'(err_to), 32'd0);
    wcnt = 0;
    while (!err_to && wcnt < 60) begin
      @(negedge clk);
      wcnt++;
    end
    check("to_err_set", 32'(err_to), 32'd1);
    wait_log(5, 60, "to_start_retry");
    check("to_retry_byte", 32'(tx_log[4]), 32'h08);
    @(negedge clk);
    en = 1'b0;
    repeat (30) @(negedge clk);
    check("to_err_cleared", 32'(err_to), 32'd0);
    check("to_idle_cs_n", 32'(cs_n), 32'd1);
    check("to_idle_busy", 32'(busy), 32'd0);

    // en low during the second read byte: byte finishes, no sample.
    tx_log.delete();
    miso.delete();
    en = 1'b1;
    wait_log(7, 400, "abort_pwr_done");
    check("abort_pwr_byte0", 32'(tx_log[0]), 32'h06);
    tx_log.delete();
    miso = '{8'h11, 8'h22, 8'h33};
    vld_base = vld_cnt;
    pulse_drdy();
    wait_log(1, 100, "abort_first_byte");
    wcnt = 0;
    while (spi_go && wcnt < 50) begin
      @(negedge clk);
      wcnt++;
    end
    while (!spi_go && wcnt < 50) begin
      @(negedge clk);
      wcnt++;
    end
    check("abort_byte2_started", 32'(spi_go), 32'd1);
    en = 1'b0;
    wcnt = 0;
    while (!cs_n && wcnt < 50) begin
      @(negedge clk);
      wcnt++;
    end
    check("abort_cs_n_high", 32'(cs_n), 32'd1);
    repeat (10) @(negedge clk);
    check("abort_nbytes", 32'(tx_log.size()), 32'd2);
    check("abort_no_vld", 32'(vld_cnt - vld_base), 32'd0);
    check("abort_sample_held", 32'(sample), 32'h00FFFFFE);
    check("abort_busy", 32'(busy), 32'd0);
    miso.delete();

    // Asynchronous reset while a byte is in flight.
    en = 1'b1;
    wcnt = 0;
    while (!spi_go && wcnt < 20) begin
      @(negedge clk);
      wcnt++;
    end
    check("arst_go_before", 32'(spi_go), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_go", 32'(spi_go), 32'd0);
    check("arst_cs_n", 32'(cs_n), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wrdat", 32'(spi_wrdat), 32'd0);
    check("arst_sample", 32'(sample), 32'd0);
    check("arst_err", 32'(err_to), 32'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("wrdat_stable", 32'(stab_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
